// File: rtl/row_pair_feeder.sv
// row_pair_feeder: sequences one matrix-times-vector job row by row.
// Each row is fetched from the row RAM and registered together with the
// vector. The pair is then handed to an external dot-product unit, and
// the scalar result is written to the result RAM.
// A watchdog replaces a hung dot product with a quiet NaN, so the job
// still completes.
// Optional feature: define ROW_FEEDER_CYCLE_COUNT_EN to add the job_cycles
// output, which counts the clock cycles of the current or most recent job.
module row_pair_feeder #(
    parameter int unsigned NI      = 8,
    parameter int unsigned NROWS   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        mat_addr,
    input  logic [32*NI-1:0]  mat_data,
    input  logic [32*NI-1:0]  vec_data,
    output logic [32*NI-1:0]  first_row_input,
    output logic [32*NI-1:0]  second_row_input,
    output logic              outsider_read_now,
    output logic              dp_reset,
    input  logic              dp_finish,
    input  logic [31:0]       dp_result,
    output logic              res_we,
    output logic [7:0]        res_addr,
    output logic [31:0]       res_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
`ifdef ROW_FEEDER_CYCLE_COUNT_EN
    ,
    output logic [31:0]       job_cycles
`endif
);

    localparam int unsigned DW    = 32 * NI;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLR      = 3'd1,
        FETCH    = 3'd2,
        LATCH    = 3'd3,
        LAUNCH   = 3'd4,
        WAIT_FIN = 3'd5,
        STORE    = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t            state_q;
    logic [7:0]        row_q;
    logic [7:0]        row_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    logic              last_row_c;
    logic              wd_expired_c;

    logic [7:0]        mat_addr_q;
    logic [DW-1:0]     first_row_q;
    logic [DW-1:0]     second_row_q;
    logic              read_now_q;
    logic              dp_reset_q;
    logic              res_we_q;
    logic [7:0]        res_addr_q;
    logic [31:0]       res_data_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_err_q;

    // Next row index, next watchdog count, and the two termination tests.
    always_comb begin
        row_d        = row_q + 8'd1;
        wd_d         = wd_q + WD_W'(1);
        last_row_c   = (row_q == 8'(NROWS - 1));
        wd_expired_c = (wd_q == WD_W'(TIMEOUT - 1));
    end

    // Job sequencer. All outputs are registered.
    // Pulse outputs default low and are raised in the cycle before the state they mark.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= 8'd0;
            wd_q          <= '0;
            mat_addr_q    <= 8'd0;
            first_row_q   <= '0;
            second_row_q  <= '0;
            read_now_q    <= 1'b0;
            dp_reset_q    <= 1'b1;
            res_we_q      <= 1'b0;
            res_addr_q    <= 8'd0;
            res_data_q    <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            dp_reset_q <= 1'b0;
            read_now_q <= 1'b0;
            res_we_q   <= 1'b0;
            done_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_q         <= 8'd0;
                        busy_q        <= 1'b1;
                        timeout_err_q <= 1'b0;
                        dp_reset_q    <= 1'b1;
                        state_q       <= CLR;
                    end
                end

                CLR: begin
                    mat_addr_q <= row_q;
                    state_q    <= FETCH;
                end

                FETCH: begin
                    state_q <= LATCH;
                end

                LATCH: begin
                    // Row and vector stay frozen until the next CLR.
                    // The consumer reads them once for each half.
                    first_row_q  <= mat_data;
                    second_row_q <= vec_data;
                    read_now_q   <= 1'b1;
                    state_q      <= LAUNCH;
                end

                LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= WAIT_FIN;
                end

                WAIT_FIN: begin
                    // Finish cannot be stale here: CLR reset the unit for this row.
                    if (dp_finish) begin
                        res_we_q   <= 1'b1;
                        res_addr_q <= row_q;
                        res_data_q <= dp_result;
                        state_q    <= STORE;
                    end else if (wd_expired_c) begin
                        timeout_err_q <= 1'b1;
                        res_we_q      <= 1'b1;
                        res_addr_q    <= row_q;
                        res_data_q    <= QNAN;
                        state_q       <= STORE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end

                STORE: begin
                    if (last_row_c) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        row_q      <= row_d;
                        dp_reset_q <= 1'b1;
                        state_q    <= CLR;
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ROW_FEEDER_CYCLE_COUNT_EN
    logic [31:0] job_cycles_q;

    // Job length counter: cleared when a job is accepted, then holds after DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_cycles_q <= 32'd0;
        end else if (state_q == IDLE && start) begin
            job_cycles_q <= 32'd0;
        end else if (busy_q) begin
            job_cycles_q <= job_cycles_q + 32'd1;
        end
    end

    assign job_cycles = job_cycles_q;
`endif

    assign mat_addr          = mat_addr_q;
    assign first_row_input   = first_row_q;
    assign second_row_input  = second_row_q;
    assign outsider_read_now = read_now_q;
    assign dp_reset          = dp_reset_q;
    assign res_we            = res_we_q;
    assign res_addr          = res_addr_q;
    assign res_data          = res_data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_row_pair_feeder.sv
// Testbench for row_pair_feeder.
// It contains a row RAM model, a dot-product unit model and a scoreboard.
// The row RAM returns valid data only in the cycle after FETCH and random
// data otherwise.
// The dot-product unit model reads the registered rows twice: once at
// launch and once at finish.
module tb_row_pair_feeder;

    localparam int NI      = 8;
    localparam int NROWS   = 4;
    localparam int TIMEOUT = 64;
    localparam int DW      = 32 * NI;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int NO_HANG = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    mat_addr;
    logic [DW-1:0] mat_data = '0;
    logic [DW-1:0] vec_data = '0;
    logic [DW-1:0] first_row_input;
    logic [DW-1:0] second_row_input;
    logic          outsider_read_now;
    logic          dp_reset;
    logic          dp_finish = 1'b0;
    logic [31:0]   dp_result = 32'd0;
    logic          res_we;
    logic [7:0]    res_addr;
    logic [31:0]   res_data;
    logic          busy;
    logic          done;
    logic          timeout_err;
`ifdef ROW_FEEDER_CYCLE_COUNT_EN
    logic [31:0]   job_cycles;
`endif

    row_pair_feeder #(.NI(NI), .NROWS(NROWS), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .mat_addr         (mat_addr),
        .mat_data         (mat_data),
        .vec_data         (vec_data),
        .first_row_input  (first_row_input),
        .second_row_input (second_row_input),
        .outsider_read_now(outsider_read_now),
        .dp_reset         (dp_reset),
        .dp_finish        (dp_finish),
        .dp_result        (dp_result),
        .res_we           (res_we),
        .res_addr         (res_addr),
        .res_data         (res_data),
        .busy             (busy),
        .done             (done),
        .timeout_err      (timeout_err)
`ifdef ROW_FEEDER_CYCLE_COUNT_EN
        ,
        .job_cycles       (job_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          to;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int last_we_cyc = -100;

    // Job configuration: matrix, vector, hung row and unit latency.
    logic [31:0] ram [NROWS][NI];
    logic [31:0] vec [NI];
    int hang_row = NO_HANG;
    int lat = 20;
    int exp_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < NI; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] half_dot(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input int lo);
        logic [31:0] s = 32'd0;
        for (int i = lo; i < lo + NI/2; i++) s = s + a[32*i +: 32] * b[32*i +: 32];
        return s;
    endfunction

    function automatic logic [31:0] ref_dot(input int r);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < NI; i++) s = s + ram[r][i] * vec[i];
        return s;
    endfunction

    // Row RAM: one-cycle read latency after FETCH, random data otherwise.
    logic fetch_next = 1'b0;
    always @(posedge clk) begin
        logic [DW-1:0] row;
        if (fetch_next && int'(mat_addr) < NROWS) begin
            for (int i = 0; i < NI; i++) row[32*i +: 32] = ram[int'(mat_addr)][i];
            mat_data <= row;
        end else begin
            mat_data <= rnd_wide();
        end
        fetch_next <= dp_reset;
    end

    // Dot-product unit model.
    // It reads the low half at launch and the high half at finish.
    // It raises finish lat+1 cycles after the launch cycle, and never does for the hung row.
    int          dp_cnt = 0;
    bit          dp_active = 1'b0;
    bit          dp_hang = 1'b0;
    logic [31:0] dp_lo = 32'd0;
    always @(posedge clk) begin
        if (dp_reset) begin
            dp_active <= 1'b0;
            dp_finish <= 1'b0;
            dp_cnt    <= 0;
            dp_result <= $urandom;
        end else if (outsider_read_now) begin
            dp_active <= 1'b1;
            dp_cnt    <= 1;
            dp_lo     <= half_dot(first_row_input, second_row_input, 0);
            dp_hang   <= (int'(mat_addr) == hang_row);
        end else if (dp_active && !dp_hang && !dp_finish) begin
            if (dp_cnt == lat) begin
                dp_finish <= 1'b1;
                dp_result <= dp_lo + half_dot(first_row_input, second_row_input, NI/2);
            end else begin
                dp_cnt <= dp_cnt + 1;
            end
        end
    end

    // Monitor: pop and compare on every result write and every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && res_we) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: addr=%0d data=%h with nothing expected", res_addr, res_data);
            end else begin
                e = sb.pop_front();
                check("we_addr", 64'(res_addr), 64'(e.addr));
                check("we_data", 64'(res_data), 64'(e.data));
                check("we_timeout_err", 64'(timeout_err), 64'(e.to));
            end
            last_we_cyc = cyc;
            wr_cnt++;
        end
        if (!reset && done) begin
            check("done_after_last_store", 64'(cyc - last_we_cyc), 64'd1);
            check("done_sb_empty", 64'(sb.size()), 64'd0);
            done_cnt++;
        end
    end

    // New random job: fill the matrix and vector, set the latency and hung row, and queue the expected writes.
    task automatic load_job(input int hang, input int l);
        exp_t e;
        hang_row = hang;
        lat      = l;
        exp_cyc  = 1;
        for (int r = 0; r < NROWS; r++)
            for (int i = 0; i < NI; i++) ram[r][i] = $urandom;
        for (int i = 0; i < NI; i++) begin
            vec[i] = $urandom;
            vec_data[32*i +: 32] = vec[i];
        end
        for (int r = 0; r < NROWS; r++) begin
            e.addr = r;
            e.data = (r == hang) ? QNAN : ref_dot(r);
            e.to   = (r >= hang);
            sb.push_back(e);
            exp_cyc += 4 + ((r == hang) ? TIMEOUT : l + 1) + 1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int n_before);
        int k = 0;
        while (done_cnt <= n_before && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt <= n_before) begin
            total++;
            bad++;
            $display("FAIL wait_done: no done within %0d cycles, expected %0d", k, n_before + 1);
        end
`ifdef ROW_FEEDER_CYCLE_COUNT_EN
        else check("job_cycles", 64'(job_cycles), 64'(exp_cyc));
`endif
    endtask

    task automatic run_job(input int hang, input int l);
        int n = done_cnt;
        load_job(hang, l);
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        exp_done++;
        wait_done(n);
    endtask

    initial begin
        int n;
        int k;
        // Hold reset and check the reset values.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dp_reset", 64'(dp_reset), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res_we", 64'(res_we), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_read_now", 64'(outsider_read_now), 64'd0);
        check("rst_mat_addr", 64'(mat_addr), 64'd0);
        check("rst_first_row_zero", 64'(first_row_input != '0), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_dp_reset_low", 64'(dp_reset), 64'd0);

        // Four rows with a unit latency of 20.
        run_job(NO_HANG, 20);
        @(posedge clk); #1;
        check("busy_cleared", 64'(busy), 64'd0);
        check("no_timeout", 64'(timeout_err), 64'd0);

        // Row 2 never finishes: it times out to qNaN and row 3 still runs.
        run_job(2, $urandom_range(12, 1));
        @(posedge clk); #1 check("timeout_sticky", 64'(timeout_err), 64'd1);

        // A second start while busy has no effect.
        n = wr_cnt;
        load_job(NO_HANG, $urandom_range(12, 1));
        pulse_start();
        exp_done++;
        k = 0;
        while (wr_cnt == n && k < 500) begin @(posedge clk); #1; k++; end
        check("row0_written_before_restart", 64'(wr_cnt > n), 64'd1);
        pulse_start();
        wait_done(exp_done - 1);
        repeat (60) @(posedge clk);
        #1 check("one_done_after_ignored_start", 64'(done_cnt), 64'(exp_done));

        // Reset three cycles into WAIT_FIN of row 1.
        n = wr_cnt;
        load_job(NO_HANG, 15);
        pulse_start();
        k = 0;
        while (wr_cnt == n && k < 500) begin @(posedge clk); #1; k++; end
        k = 0;
        while (!outsider_read_now && k < 500) begin @(posedge clk); #1; k++; end
        check("row1_launched", 64'(outsider_read_now), 64'd1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        n = wr_cnt;
        k = done_cnt;
        @(posedge clk); #1;
        check("midrst_dp_reset", 64'(dp_reset), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_res_we", 64'(res_we), 64'd0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_more_writes", 64'(wr_cnt), 64'(n));
        check("midrst_no_done", 64'(done_cnt), 64'(k));

        // After the reset, a new start begins again at row 0.
        run_job(NO_HANG, $urandom_range(20, 1));

        // Random jobs, some of them with a hung row.
        for (int j = 0; j < 4; j++)
            run_job(($urandom_range(3, 0) == 0) ? int'($urandom_range(NROWS - 1, 0)) : NO_HANG,
                    $urandom_range(20, 1));

        repeat (5) @(posedge clk);
        #1;
        check("final_done_count", 64'(done_cnt), 64'(exp_done));
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/row_pair_feeder.md
ROW_PAIR_FEEDER -- requirements
Module: row_pair_feeder

Interface
REQ-001 Parameter NI, default 8: elements per row package; each element 32-bit; legal values 8, 16.
REQ-002 Parameter NROWS, default 8: matrix rows processed per job; legal range 1..256.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles allowed between launch and dot-product finish.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  job request; sampled only in IDLE.
REQ-007 mat_addr  out  8  matrix row address to the row RAM.
REQ-008 mat_data  in  32*NI  matrix row data; valid exactly 1 cycle after mat_addr is driven.
REQ-009 vec_data  in  32*NI  vector operand; must be held stable by the system for the whole job.
REQ-010 first_row_input  out  32*NI  registered matrix row to the dot-product unit.
REQ-011 second_row_input  out  32*NI  registered vector to the dot-product unit.
REQ-012 outsider_read_now  out  1  one-cycle launch pulse to the dot-product unit.
REQ-013 dp_reset  out  1  synchronous reset to the dot-product unit.
REQ-014 dp_finish  in  1  finish level from the dot-product unit.
REQ-015 dp_result  in  32  dot-product output; valid while dp_finish=1.
REQ-016 res_we, res_addr, res_data  out  1/8/32  result-RAM write strobe, row index, and value.
REQ-017 busy, done, timeout_err  out  1/1/1  status outputs.

Function
REQ-018 The FSM SHALL have the states IDLE, CLR, FETCH, LATCH, LAUNCH, WAIT_FIN, STORE, DONE.
REQ-019 IDLE: start=1 SHALL set row=0, set busy=1, and move to CLR.
REQ-020 CLR SHALL drive dp_reset=1 for exactly 1 cycle, then move to FETCH.
REQ-021 FETCH SHALL drive mat_addr=row and move to LATCH; LATCH SHALL register mat_data into first_row_input and vec_data into second_row_input, then move to LAUNCH.
REQ-022 LAUNCH SHALL drive outsider_read_now=1 for exactly 1 cycle, clear the watchdog counter, and move to WAIT_FIN.
REQ-023 first_row_input and second_row_input SHALL remain stable from LATCH until the next CLR; the consumer samples them twice, once per half.
REQ-024 WAIT_FIN: dp_finish=1 SHALL move to STORE; otherwise the watchdog SHALL increment each cycle.
REQ-025 If the watchdog reaches TIMEOUT, the block SHALL set timeout_err=1 (sticky until start or reset), write res_data=32'h7FC00000 (qNaN), and enter STORE.
REQ-026 STORE SHALL pulse res_we=1 for 1 cycle with res_addr=row and res_data=dp_result (or qNaN on timeout).
REQ-027 After STORE: if row==NROWS-1, go to DONE; otherwise increment row and go to CLR.
REQ-028 DONE SHALL pulse done=1 for 1 cycle, clear busy, and return to IDLE.
REQ-029 Row-to-row latency SHALL be 5 cycles plus the dot-product latency.
REQ-030 start asserted while busy=1 SHALL be ignored.
REQ-031 row SHALL be 8 bits and SHALL never wrap; termination is by comparison with NROWS-1.
REQ-032 A dp_finish already high on entry to WAIT_FIN cannot be stale, because CLR always precedes it.

Reset
REQ-033 reset=1 SHALL force IDLE, row=0, and set all outputs to 0, except dp_reset, which SHALL be 1 while reset=1.
REQ-034 reset asserted mid-job SHALL abandon the job with no further res_we; done SHALL NOT pulse.

Configuration
REQ-035 Macro ROW_FEEDER_CYCLE_COUNT_EN defined: add output job_cycles (32 bits), counting clk cycles while busy=1, cleared on start, holding its final value after DONE.
REQ-036 Macro ROW_FEEDER_CYCLE_COUNT_EN undefined: no job_cycles port and no counter logic.

Verification
REQ-037 NI=8, NROWS=4, model finish 20 cycles after read_now -> four res_we pulses at addresses 0..3, then done exactly 1 cycle after the last STORE.
REQ-038 Row 2 model never asserts finish, TIMEOUT=64 -> 64 cycles after launch: res_data=32'h7FC00000 at res_addr=2, timeout_err=1, and rows 3.. still processed.
REQ-039 start pulsed again at row 1 of a running job -> ignored; exactly NROWS writes, one done.
REQ-040 reset asserted 3 cycles into WAIT_FIN of row 1 -> IDLE next cycle, dp_reset=1, no res_we; a subsequent start restarts from row 0.
REQ-041 Cycle count enabled, NROWS=1, finish latency 10 -> job_cycles=17 after done.
REQ-042 mat_data changes in the cycle after LATCH -> first_row_input unchanged until the next CLR.
